// File: rtl/bridge_pkg.sv
// Shared frame geometry, command codes and FSM states for the UART bridge.
// Frame timeout in the assembler is enabled by defining FRAME_TIMEOUT_EN.
package bridge_pkg;

  localparam int FRAME_W     = 56;
  localparam int FRAME_BYTES = 7;

  localparam logic [4:0] SYNC_DEFAULT = 5'b10110;

  typedef enum logic [2:0] {
    WREQ = 3'd2,
    RREQ = 3'd3,
    RRES = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PUSH
  } asm_state_e;

  function automatic logic sync_ok(
    input logic [7:0] b,
    input logic [4:0] s
  );
    return b[7:3] == s;
  endfunction

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out bundle between UART receiver, assembler
// and command decoder.
interface uart_frame_assembler_if;
  import bridge_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_err;
  logic               rd_en;
  logic [FRAME_W-1:0] frame_data;
  logic               empty;
  logic               full;
  logic               frame_err;
  logic               overflow;

  modport master (
    output rx_data, rx_valid, rx_err, rd_en,
    input  frame_data, empty, full, frame_err, overflow
  );

  modport slave (
    input  rx_data, rx_valid, rx_err, rd_en,
    output frame_data, empty, full, frame_err, overflow
  );

endinterface

// File: rtl/frame_fifo.sv
// DEPTH x FRAME_W frame buffer with a registered read port that
// holds the last popped frame until the next pop.
module frame_fifo
  import bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] din,
  output logic [FRAME_W-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [FRAME_W-1:0] mem_d [DEPTH];
  logic [FRAME_W-1:0] dout_q, dout_d;
  logic               do_pop, do_push;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign dout  = dout_q;

  // A pop frees the slot, so a push while full is legal alongside it.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) begin
      dout_d = mem_q[rptr_q];
      rptr_d = rptr_q + AW'(1);
    end
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles seven UART bytes (MSB first) into a 56-bit frame and queues it.
// Define FRAME_TIMEOUT_EN to abort frames idle for TIMEOUT_CYCLES.
module uart_frame_assembler
  import bridge_pkg::*;
#(
  parameter int         DEPTH          = 4,
  parameter logic [4:0] SYNC           = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst,
  uart_frame_assembler_if.slave bus
);

  asm_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               ferr_q, ferr_d;
  logic               ovf_q, ovf_d;
  logic               push;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    ferr_d  = 1'b0;
    ovf_d   = 1'b0;
    push    = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    tmo_d   = '0;
`endif
    unique case (state_q)
      // PUSH also acts as IDLE for a byte arriving right behind the frame.
      S_IDLE, S_PUSH: begin
        if (state_q == S_PUSH) begin
          push  = !bus.full || bus.rd_en;
          ovf_d = !push;
        end
        state_d = S_IDLE;
        cnt_d   = '0;
        if (bus.rx_valid) begin
          if (sync_ok(bus.rx_data, SYNC)) begin
            frame_d = {{(FRAME_W-8){1'b0}}, bus.rx_data};
            cnt_d   = 3'd1;
            state_d = S_COLLECT;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (bus.rx_err) begin
          ferr_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (bus.rx_valid) begin
          frame_d = {frame_q[FRAME_W-9:0], bus.rx_data};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'(FRAME_BYTES - 1)) state_d = S_PUSH;
        end
`ifdef FRAME_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          ferr_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
`ifdef FRAME_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.frame_err = ferr_q;
  assign bus.overflow  = ovf_q;

  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (bus.rd_en),
    .din  (frame_q),
    .dout (bus.frame_data),
    .empty(bus.empty),
    .full (bus.full)
  );

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed plus randomized bench for uart_frame_assembler with a
// queue-based reference model checked every cycle.
module tb_uart_frame_assembler;
  import bridge_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_frame_assembler_if bus ();

  uart_frame_assembler #(
    .DEPTH         (DEPTH),
    .SYNC          (SYNC_DEFAULT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: frames as queues of bytes and a queue of frames.
  logic [55:0] mq[$];
  logic [7:0]  cur[$];
  bit          pend;
  logic [55:0] pend_f;
  int          idle;
  logic [55:0] m_data;
  bit          m_ferr, m_ovf;
  int          m_n;
  bit          s_rst, s_v, s_e, s_rd;
  logic [7:0]  s_d;
  int          ferr_seen = 0;
  int          ovf_seen  = 0;

  function automatic logic [55:0] pack();
    logic [55:0] f = '0;
    foreach (cur[i]) f = {f[47:0], cur[i]};
    return f;
  endfunction

  always @(posedge clk) begin
    if (rst && bus.frame_err) ferr_seen++;
    if (rst && bus.overflow)  ovf_seen++;
  end

  initial begin : model
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_v   = bus.rx_valid;
      s_e   = bus.rx_err;
      s_rd  = bus.rd_en;
      s_d   = bus.rx_data;
      m_ferr = 0;
      m_ovf  = 0;
      if (!s_rst) begin
        mq.delete();
        cur.delete();
        pend   = 0;
        idle   = 0;
        m_data = '0;
      end else begin
        m_n = mq.size();
        if (s_rd && m_n > 0) m_data = mq.pop_front();
        if (pend) begin
          if (m_n < DEPTH || s_rd) mq.push_back(pend_f);
          else m_ovf = 1;
          pend = 0;
        end
        if (cur.size() == 0) begin
          if (s_v) begin
            if (s_d[7:3] == SYNC_DEFAULT) begin
              cur.push_back(s_d);
              idle = 0;
            end else m_ferr = 1;
          end
        end else if (s_e) begin
          m_ferr = 1;
          cur.delete();
        end else if (s_v) begin
          cur.push_back(s_d);
          idle = 0;
          if (cur.size() == FRAME_BYTES) begin
            pend   = 1;
            pend_f = pack();
            cur.delete();
          end
        end
`ifdef FRAME_TIMEOUT_EN
        else begin
          idle++;
          if (idle == TMO) begin
            m_ferr = 1;
            cur.delete();
          end
        end
`endif
      end
      #1;
      if (s_rst) begin
        chk("m_data", bus.frame_data, m_data);
        chk("m_empty", bus.empty, mq.size() == 0);
        chk("m_full", bus.full, mq.size() == DEPTH);
        chk("m_ferr", bus.frame_err, m_ferr);
        chk("m_ovf", bus.overflow, m_ovf);
      end
    end
  end

  // Stimulus helpers
  bit rand_rd = 0;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rd) bus.rd_en = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    cyc(1);
    bus.rx_valid = 1'b0;
    cyc(gap);
  endtask

  task automatic send_frame(input logic [55:0] f, input int gap);
    for (int i = 0; i < FRAME_BYTES; i++)
      send_byte(f[55-8*i -: 8], gap);
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    cyc(1);
    bus.rd_en = 1'b0;
  endtask

  function automatic logic [55:0] rnd_frame();
    logic [63:0] r = {$urandom(), $urandom()};
    logic [55:0] f = r[55:0];
    f[55:51] = SYNC_DEFAULT;
    return f;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"}, bus.frame_data, 56'h0);
    chk({tag, "_empty"}, bus.empty, 1'b1);
    chk({tag, "_full"}, bus.full, 1'b0);
    chk({tag, "_ferr"}, bus.frame_err, 1'b0);
    chk({tag, "_ovf"}, bus.overflow, 1'b0);
  endtask

  logic [55:0] fq[6];
  logic [55:0] fa, fb;
  logic [7:0]  bb;
  int          e0, o0, kind, nb;

  initial begin : stim
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    bus.rd_en    = 1'b0;
    cyc(3);
    chk_reset_outs("reset");
    @(negedge clk) rst = 1'b1;
    cyc(2);

    // Known frame, bytes 16 cycles apart
    fa = 56'hB2_1234_DEADBEEF;
    for (int i = 0; i < 6; i++) send_byte(fa[55-8*i -: 8], 15);
    bus.rx_data  = 8'hEF;
    bus.rx_valid = 1'b1;
    cyc(1);
    bus.rx_valid = 1'b0;
    chk("t1_empty_push", bus.empty, 1'b1);
    cyc(1);
    chk("t1_empty_fall", bus.empty, 1'b0);
    pop();
    chk("t1_data", bus.frame_data, 56'hB2_1234_DEADBEEF);
    cyc(5);
    chk("t1_hold", bus.frame_data, 56'hB2_1234_DEADBEEF);

    // Bad sync byte, then a good frame
    e0 = ferr_seen;
    send_byte(8'h42, 0);
    chk("sync_pulse", bus.frame_err, 1'b1);
    cyc(1);
    chk("sync_pulse_end", bus.frame_err, 1'b0);
    fa = rnd_frame();
    send_frame(fa, 1);
    cyc(2);
    pop();
    chk("sync_next", bus.frame_data, fa);
    chk("sync_ferr_n", ferr_seen - e0, 1);

    // rx_err mid-frame
    e0 = ferr_seen;
    fa = rnd_frame();
    fb = rnd_frame();
    for (int i = 0; i < 3; i++) send_byte(fa[55-8*i -: 8], 0);
    bus.rx_err = 1'b1;
    cyc(1);
    bus.rx_err = 1'b0;
    send_frame(fb, 0);
    cyc(3);
    chk("err_ferr_n", ferr_seen - e0, 1);
    pop();
    chk("err_data", bus.frame_data, fb);
    chk("err_empty", bus.empty, 1'b1);

    // Fill, overflow, drain in order
    o0 = ovf_seen;
    for (int i = 0; i < 5; i++) begin
      fq[i] = rnd_frame();
      send_frame(fq[i], 0);
    end
    cyc(3);
    chk("ovf_full", bus.full, 1'b1);
    chk("ovf_n", ovf_seen - o0, 1);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("ovf_order", bus.frame_data, fq[i]);
    end
    chk("ovf_drained", bus.empty, 1'b1);

    // Fifth frame completes with a pop in the PUSH cycle
    o0 = ovf_seen;
    for (int i = 0; i < 5; i++) fq[i] = rnd_frame();
    for (int i = 0; i < 4; i++) send_frame(fq[i], 0);
    for (int i = 0; i < 6; i++) send_byte(fq[4][55-8*i -: 8], 0);
    bus.rx_data  = fq[4][7:0];
    bus.rx_valid = 1'b1;
    cyc(1);
    bus.rx_valid = 1'b0;
    bus.rd_en    = 1'b1;
    cyc(1);
    bus.rd_en    = 1'b0;
    cyc(2);
    chk("pushpop_ovf", ovf_seen - o0, 0);
    chk("pushpop_full", bus.full, 1'b1);
    chk("pushpop_data", bus.frame_data, fq[0]);
    for (int i = 1; i < 5; i++) begin
      pop();
      chk("pushpop_order", bus.frame_data, fq[i]);
    end

    // Pop while empty leaves frame_data alone
    pop();
    chk("empty_pop", bus.frame_data, fq[4]);

    // Reset mid-frame with a buffered frame
    fa = rnd_frame();
    send_frame(fa, 0);
    fb = rnd_frame();
    for (int i = 0; i < 5; i++) send_byte(fb[55-8*i -: 8], 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk) rst = 1'b1;
    cyc(1);
    fb = rnd_frame();
    send_frame(fb, 0);
    cyc(2);
    pop();
    chk("rst_next", bus.frame_data, fb);

`ifdef FRAME_TIMEOUT_EN
    e0 = ferr_seen;
    fa = rnd_frame();
    for (int i = 0; i < 2; i++) send_byte(fa[55-8*i -: 8], 0);
    send_byte(fa[39:32], TMO);
    cyc(3);
    chk("tmo_ferr_n", ferr_seen - e0, 1);
    chk("tmo_empty", bus.empty, 1'b1);
    e0 = ferr_seen;
    fb = rnd_frame();
    for (int i = 0; i < 7; i++)
      send_byte(fb[55-8*i -: 8], (i == 2) ? TMO - 1 : 0);
    cyc(2);
    chk("tmo_edge_ferr", ferr_seen - e0, 0);
    pop();
    chk("tmo_edge_data", bus.frame_data, fb);
`endif

    // Random traffic with random pops
    rand_rd = 1;
    repeat (200) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        fa = rnd_frame();
        for (int i = 0; i < 7; i++)
          send_byte(fa[55-8*i -: 8], $urandom_range(0, 2));
      end else if (kind == 7) begin
        do bb = 8'($urandom()); while (bb[7:3] == SYNC_DEFAULT);
        send_byte(bb, $urandom_range(0, 2));
      end else begin
        fa = rnd_frame();
        nb = $urandom_range(1, 6);
        for (int i = 0; i < nb; i++) send_byte(fa[55-8*i -: 8], 0);
        bus.rx_err   = 1'b1;
        bus.rx_valid = 1'($urandom_range(0, 1));
        bus.rx_data  = 8'($urandom());
        cyc(1);
        bus.rx_err   = 1'b0;
        bus.rx_valid = 1'b0;
        cyc($urandom_range(0, 3));
      end
    end
    rand_rd = 0;
    bus.rd_en = 1'b0;
    cyc(3);
    repeat (DEPTH + 1) pop();
    chk("final_empty", bus.empty, 1'b1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
# uart_frame_assembler

Collects bytes from the UART receiver into 56-bit bridge frames and buffers complete frames in a small FIFO for the command decoder. It sits directly upstream of the decoder. Its `rd_en` input is driven by the decoder's read-enable. The decoder samples `frame_data` one cycle after asserting `rd_en`, so popped data is registered and held until the next pop. Malformed, aborted or overflowing frames are dropped and flagged.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in frames; power of two, ≥2.
- `SYNC`, 5'b10110: required value of frame bits [55:51], which are the upper 5 bits of the first byte.
- `TIMEOUT_CYCLES`, 1024: maximum idle clk cycles between bytes of one frame (only with the macro).

Ports (reset rst, asynchronous, active-low; clock clk):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid.
- `rx_err` in 1: one-cycle strobe from the UART receiver for a framing or parity error.
- `rd_en` in 1: pop request.
- `frame_data` out 56: last popped frame, held between pops.
- `empty` out 1: FIFO holds no frames.
- `full` out 1: FIFO holds DEPTH frames.
- `frame_err` out 1: one-cycle pulse when a frame is discarded for bad sync, `rx_err` or timeout.
- `overflow` out 1: one-cycle pulse when a complete frame is dropped because the FIFO is full.

## Operation
- Byte order is MSB first: the first byte forms [55:48] and the seventh forms [7:0]. The command field is [50:48].
- States:
  - IDLE: on `rx_valid`, if `rx_data[7:5]==SYNC[4:2]` and `rx_data[4:3]==SYNC[1:0]` (that is, `rx_data[7:3]==SYNC`), load the byte, set byte count to 1 and go to COLLECT. Otherwise pulse `frame_err` and stay in IDLE.
  - COLLECT: on `rx_valid`, shift the byte in and increment the count. When the seventh byte arrives, go to PUSH. On `rx_err`, pulse `frame_err`, clear the count and go to IDLE. `rx_err` wins over a simultaneous `rx_valid`.
  - PUSH: lasts one cycle. Write the frame if `!full || rd_en`. Otherwise drop it and pulse `overflow`. Always return to IDLE.
    - An `rx_valid` arriving during PUSH is evaluated as an IDLE first byte in the same cycle: it is sync-checked, and on pass the FSM goes to COLLECT with count 1.
- `rx_err` in IDLE or PUSH is ignored.
- FIFO:
  - Write pointer, read pointer and an occupancy counter of width $clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop while full is legal: occupancy stays at DEPTH.
  - A simultaneous push and pop while empty pops nothing; the push lands.
  - `rd_en` while empty is ignored, and `frame_data` is unchanged.
- Reset values: state IDLE, count 0, pointers 0, `frame_data`=0, `empty`=1, `full`=0, `frame_err`=0, `overflow`=0.
- Reset mid-frame discards the partial frame and all buffered frames.

## Timing
- If byte 7 is strobed in cycle N: PUSH occurs in cycle N+1, and `empty` falls (or occupancy increments) from cycle N+2.
- `rd_en` in cycle M: `frame_data` holds the popped frame from cycle M+1 until the next successful pop. `empty`/`full` update from M+1.
- `frame_err` and `overflow` are registered and asserted in the cycle after the causing event.
- No throughput limit beyond one byte per cycle.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) runs while in COLLECT and clears on each accepted byte.
  - After TIMEOUT_CYCLES consecutive cycles without `rx_valid`, pulse `frame_err` and go to IDLE.
  - An `rx_valid` in the terminal cycle is accepted, and the timeout does not fire.
- `FRAME_TIMEOUT_EN` undefined: no counter; COLLECT waits indefinitely.

## Structure
- Shared package `bridge_pkg`:
  - FRAME_W=56 and FRAME_BYTES=7.
  - Command codes WREQ=3'd2, RREQ=3'd3, RRES=3'd4.
  - Default SYNC.
  - FSM state enum.
- One sub-module, `frame_fifo`: the DEPTH×56 storage with pointers, occupancy, the registered read output and full/empty. The assembler FSM stays in the top level.

## Test plan
- Bytes B2 12 34 DE AD BE EF, each strobed 16 cycles apart -> `empty` falls 2 cycles after the EF strobe. After `rd_en`, `frame_data`=56'hB2_1234_DEADBEEF, stable until the next pop.
- First byte 0x42 -> `frame_err` pulses once and the state stays IDLE. Then a valid 7-byte frame -> accepted normally.
- `rx_err` after 3 bytes, then a full valid frame -> one `frame_err`. Only the second frame appears, with its correct value.
- Push 4 frames with DEPTH=4 -> `full`=1. A fifth frame -> `overflow` pulse, and 4 pops return frames 1–4 in order. A fifth frame completing with `rd_en` in the PUSH cycle -> no overflow, `full` stays 1.
- `rd_en` while empty -> `frame_data` unchanged. Assert `rst` after 5 bytes -> all outputs at reset values, and the next valid frame is assembled cleanly.
- With `FRAME_TIMEOUT_EN` and TIMEOUT_CYCLES=1024: 3 bytes, then a 1024-cycle gap -> `frame_err`, nothing pushed. A gap of 1023 cycles -> the frame completes normally.
